sysbus_mem_responder: RTL

//  Memory-side end of the Sysbus: accepts line requests from an initiator (fetch/translation logic),

---
 rtl/sysbus_mem_responder_pkg.sv | 32 +++
 rtl/sysbus_mem_responder_if.sv | 27 ++
 rtl/sysbus_mem_responder_mem_array.sv | 32 +++
 rtl/sysbus_mem_responder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/sysbus_mem_responder_pkg.sv
// Shared Sysbus encodings: direction and target codes, tag field positions,
// and the responder state type. The core's bus logic uses the same encodings.
package sysbus_mem_responder_pkg;

    localparam int SYSBUS_TAG_W = 13;

    // Tag layout: [12] direction, [11:8] target type, [7:0] initiator id
    localparam int DIR_BIT  = 12;
    localparam int TYPE_MSB = 11;
    localparam int TYPE_LSB = 8;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;
    localparam logic [3:0] SYSBUS_MMIO   = 4'h2;

    typedef enum logic [1:0] {
        IDLE,
        RWAIT,
        RBURST,
        WDATA
    } state_t;

    function automatic logic tag_is_memory(input logic [SYSBUS_TAG_W-1:0] tag);
        return tag[TYPE_MSB:TYPE_LSB] == SYSBUS_MEMORY;
    endfunction

    function automatic logic tag_is_read(input logic [SYSBUS_TAG_W-1:0] tag);
        return tag[DIR_BIT] == SYSBUS_READ;
    endfunction

endpackage

// File: rtl/sysbus_mem_responder_if.sv
// Sysbus request/response channel. The initiator drives the master side,
// the memory responder sits on the slave side.
interface sysbus_mem_responder_if
    import sysbus_mem_responder_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int TAG_W  = SYSBUS_TAG_W
);
    logic              bus_reqcyc;
    logic              bus_reqack;
    logic [DATA_W-1:0] bus_req;
    logic [TAG_W-1:0]  bus_reqtag;
    logic              bus_respcyc;
    logic              bus_respack;
    logic [DATA_W-1:0] bus_resp;
    logic [TAG_W-1:0]  bus_resptag;

    modport master (
        output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );

    modport slave (
        input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
        output bus_reqack, bus_respcyc, bus_resp, bus_resptag
    );
endinterface

// File: rtl/sysbus_mem_responder_mem_array.sv
// Backing store: 1R1W synchronous RAM with registered read data.
// Zero-filled at power-up.
module sysbus_mem_responder_mem_array #(
    parameter int    MEM_WORDS = 8192,
    parameter int    DATA_W    = 64,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(MEM_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem_q [MEM_WORDS];
    logic [DATA_W-1:0] rdata_q;

    // Power-up image of the store
    initial begin
        for (int i = 0; i < MEM_WORDS; i++) mem_q[i] = '0;
    end

    // Write port and registered read port
    // NOTE: the store has no reset so it maps onto block RAM; reset only touches the control path.
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdata;
        rdata_q <= mem_q[raddr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side Sysbus responder: accepts line requests, streams read bursts
// from the backing store and absorbs write bursts into it.
module sysbus_mem_responder
    import sysbus_mem_responder_pkg::*;
#(
    parameter int    BUS_DATA_WIDTH = 64,
    parameter int    BUS_TAG_WIDTH  = 13,
    parameter int    MEM_WORDS      = 8192,
    parameter int    BURST_LEN      = 8,
    parameter int    READ_LATENCY   = 4,
    parameter string INIT_FILE      = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    sysbus_mem_responder_if.slave bus
);
    localparam int AW     = $clog2(MEM_WORDS);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int OFS_W  = BEAT_W + $clog2(BUS_DATA_WIDTH / 8);
    localparam int LINE_W = AW - BEAT_W;
    localparam int LAT_W  = $clog2(READ_LATENCY + 1);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [LAT_W-1:0]  LAST_WAIT = LAT_W'(READ_LATENCY - 1);

    state_t                   state_q, state_d;
    logic [LAT_W-1:0]         lat_q, lat_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [BEAT_W-1:0]        beat_nxt;
    logic [LINE_W-1:0]        line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;

    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [AW-1:0]             mem_raddr;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;

    assign beat_nxt = beat_q + 1'b1;

    sysbus_mem_responder_mem_array #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (BUS_DATA_WIDTH),
        .INIT_FILE (INIT_FILE)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (bus.bus_req),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Next-state, bus outputs and RAM control
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        lat_d   = lat_q;
        beat_d  = beat_q;
        line_d  = line_q;
        tag_d   = tag_q;

        bus.bus_reqack  = 1'b0;
        bus.bus_respcyc = 1'b0;
        bus.bus_resp    = '0;
        bus.bus_resptag = '0;

        mem_we    = 1'b0;
        mem_waddr = {line_q, beat_q};
        mem_raddr = {line_q, beat_q};

        case (state_q)
            IDLE: begin
                if (bus.bus_reqcyc && tag_is_memory(bus.bus_reqtag)) begin
                    bus.bus_reqack = 1'b1;
                    line_d  = bus.bus_req[OFS_W +: LINE_W];
                    tag_d   = bus.bus_reqtag;
                    beat_d  = '0;
                    lat_d   = '0;
                    state_d = tag_is_read(bus.bus_reqtag) ? RWAIT : WDATA;
                end
            end
            RWAIT: begin
                // beat_q is 0 here, so the default read address prefetches beat 0
                if (lat_q == LAST_WAIT) state_d = RBURST;
                else                    lat_d   = lat_q + 1'b1;
            end
            RBURST: begin
                bus.bus_respcyc = 1'b1;
                bus.bus_resp    = mem_rdata;
                bus.bus_resptag = tag_q;
                if (bus.bus_respack) begin
                    // Fetch the following word now so the next beat has no bubble
                    mem_raddr = {line_q, beat_nxt};
                    beat_d    = beat_nxt;
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            WDATA: begin
                bus.bus_reqack = bus.bus_reqcyc;
                if (bus.bus_reqcyc) begin
                    mem_we = 1'b1;
                    beat_d = beat_nxt;
                    if (beat_q == LAST_BEAT) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control-path registers with synchronous reset
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            lat_q   <= '0;
            beat_q  <= '0;
            line_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_d;
            beat_q  <= beat_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
        end
    end
endmodule
